// File: rtl/reg_file_wr_arbiter.sv
// Write-port controller for the register file: clears x1..x(REG_NUM-1) after reset,
// then round-robin arbitrates REQ_NUM writeback requesters onto a registered write port.
module reg_file_wr_arbiter #(
    parameter int REQ_NUM    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_NUM    = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REQ_NUM-1:0]             req_valid,
    input  logic [REQ_NUM*ADDR_WIDTH-1:0]  req_waddr,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]  req_wdata,
    output logic [REQ_NUM-1:0]             req_ready,
    output logic                           rf_wen,
    output logic [ADDR_WIDTH-1:0]          rf_waddr,
    output logic [DATA_WIDTH-1:0]          rf_wdata,
    output logic                           init_done
);

    localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    // One extra bit so the counter can reach REG_NUM, which marks the end of the clear.
    localparam int CNT_W = ADDR_WIDTH + 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        clr_cnt_q, clr_cnt_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                    rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
    logic                    init_done_q, init_done_d;

    logic                    grant_vld;
    logic [PTR_W-1:0]        grant_idx;
    logic                    xfer;
    logic [ADDR_WIDTH-1:0]   sel_waddr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    // Round-robin scan starting at rr_ptr; first valid requester wins.
    always_comb begin : arb_comb
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int j = 0; j < REQ_NUM; j++) begin
            idx = (int'(rr_ptr_q) + j) % REQ_NUM;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
    end

    assign sel_waddr = req_waddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign xfer      = |(req_valid & req_ready);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            clr_cnt_q   <= CNT_W'(1);
            rr_ptr_q    <= '0;
            rf_wen_q    <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            rf_wen_q    <= rf_wen_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            init_done_q <= init_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && clr_cnt_q == CNT_W'(REG_NUM)) begin
            state_d = ST_RUN;
        end
    end

    // Grant output
    always_comb begin
        req_ready = '0;
        if (state_q == ST_RUN && grant_vld) begin
            req_ready[grant_idx] = init_done_q;
        end
    end

    // Registered write port and bookkeeping
    always_comb begin
        clr_cnt_d   = clr_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        rf_wen_d    = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        init_done_d = init_done_q;
        if (state_q == ST_INIT) begin
            if (clr_cnt_q < CNT_W'(REG_NUM)) begin
                rf_wen_d   = 1'b1;
                rf_waddr_d = clr_cnt_q[ADDR_WIDTH-1:0];
                rf_wdata_d = '0;
                clr_cnt_d  = clr_cnt_q + CNT_W'(1);
            end else begin
                init_done_d = 1'b1;
            end
        end else if (xfer) begin
            // x0 writes are consumed but never reach the register file.
            rf_waddr_d = sel_waddr;
            rf_wdata_d = sel_wdata;
            rf_wen_d   = (sel_waddr != '0);
            rr_ptr_d   = (int'(grant_idx) == REQ_NUM - 1) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    assign rf_wen    = rf_wen_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Bench for reg_file_wr_arbiter: directed scenarios plus contract-respecting random traffic,
// checked cycle by cycle against an edge-counting / round-robin reference model.
module tb_reg_file_wr_arbiter;
    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int RN = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_waddr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_ready;
    logic              rf_wen;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic              init_done;

    reg_file_wr_arbiter #(.REQ_NUM(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_NUM(RN)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_waddr(req_waddr),
        .req_wdata(req_wdata), .req_ready(req_ready), .rf_wen(rf_wen),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit            m_done;
    int            m_cnt;
    int            m_rr;
    bit            m_wen;
    int            m_waddr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rf [RN];
    logic [DW-1:0] d_rf [RN];
    logic [N-1:0]  last_ready;
    int            wen_cnt;
    bit            pend [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input int i, input logic v, input int addr, input logic [DW-1:0] data);
        req_valid[i]           = v;
        req_waddr[i*AW +: AW]  = AW'(addr);
        req_wdata[i*DW +: DW]  = data;
    endtask

    // One clock: check the grant, advance the model across the edge, check the write port.
    task automatic tick();
        logic [N-1:0] er;
        int w;
        @(negedge clk);
        er = '0;
        w  = -1;
        if (m_done) begin
            for (int j = 0; j < N; j++) begin
                if (w < 0 && req_valid[(m_rr + j) % N]) w = (m_rr + j) % N;
            end
        end
        if (w >= 0) er[w] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        last_ready = req_ready;
        if (rst) begin
            m_done = 0; m_cnt = 0; m_rr = 0; m_wen = 0; m_waddr = 0; m_wdata = '0;
        end else if (!m_done) begin
            m_cnt++;
            if (m_cnt < RN) begin
                m_wen = 1; m_waddr = m_cnt; m_wdata = '0;
            end else begin
                m_wen = 0; m_done = 1;
            end
        end else if (w >= 0) begin
            m_waddr = int'(req_waddr[w*AW +: AW]);
            m_wdata = req_wdata[w*DW +: DW];
            m_wen   = (m_waddr != 0);
            m_rr    = (w + 1) % N;
        end else begin
            m_wen = 0;
        end
        @(posedge clk);
        #1;
        chk("rf_wen", 64'(rf_wen), 64'(m_wen));
        chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
        chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
        chk("init_done", 64'(init_done), 64'(m_done));
        if (m_wen) m_rf[m_waddr] = m_wdata;
        if (rf_wen) begin
            d_rf[rf_waddr] = rf_wdata;
            wen_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_waddr = '0; req_wdata = '0;
        m_done = 0; m_cnt = 0; m_rr = 0; m_wen = 0; m_waddr = 0; m_wdata = '0;
        for (int r = 0; r < RN; r++) begin
            m_rf[r] = (r == 0) ? '0 : 32'hDEAD_BEEF;
            d_rf[r] = (r == 0) ? '0 : 32'hDEAD_BEEF;
        end
        @(posedge clk); #1;
        tick(); tick();

        // 1: clear sequence
        rst = 1'b0;
        wen_cnt = 0;
        repeat (40) tick();
        chk("clear_wen_cycles", 64'(wen_cnt), 64'd31);
        chk("clear_init_done", 64'(init_done), 64'd1);
        for (int r = 0; r < RN; r++) chk($sformatf("clear_x%0d", r), 64'(d_rf[r]), 64'd0);

        // 2: both requesters valid, grants alternate
        drive(0, 1'b1, 5, 32'hA);
        drive(1, 1'b1, 6, 32'hB);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("alt_grant", 64'(last_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
        end
        drive(0, 1'b0, 0, '0); drive(1, 1'b0, 0, '0);
        tick();
        chk("alt_x5", 64'(d_rf[5]), 64'hA);
        chk("alt_x6", 64'(d_rf[6]), 64'hB);

        // 3: single valid requester granted every cycle
        drive(1, 1'b1, 7, 32'h1234);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("single_ready", 64'(last_ready), 64'd2);
            chk("single_wen", 64'(rf_wen), 64'd1);
        end
        drive(1, 1'b0, 0, '0);
        tick();

        // 4: x0 write is consumed without a commit; pointer moves to r1
        drive(0, 1'b1, 0, 32'hFFFF_FFFF);
        tick();
        chk("x0_ready", 64'(last_ready), 64'd1);
        chk("x0_wen", 64'(rf_wen), 64'd0);
        drive(0, 1'b1, 3, 32'h1);
        drive(1, 1'b1, 4, 32'h2);
        tick();
        chk("x0_rr_adv", 64'(last_ready), 64'd2);
        drive(1, 1'b0, 0, '0);
        tick();
        drive(0, 1'b0, 0, '0);
        drive(1, 1'b1, 4, 32'h2);
        tick();
        drive(1, 1'b0, 0, '0);
        chk("x0_reads0", 64'(d_rf[0]), 64'd0);

        // 5: same destination from both, later grant wins
        drive(0, 1'b1, 9, 32'h11);
        drive(1, 1'b1, 9, 32'h22);
        tick();
        chk("same_first", 64'(last_ready), 64'd1);
        drive(0, 1'b0, 0, '0);
        tick();
        chk("same_second", 64'(last_ready), 64'd2);
        drive(1, 1'b0, 0, '0);
        tick();
        chk("same_x9", 64'(d_rf[9]), 64'h22);

        // 6: reset during INIT at edge 10 restarts the clear
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (9) tick();
        rst = 1'b1; tick();
        chk("rst_wen", 64'(rf_wen), 64'd0);
        chk("rst_done", 64'(init_done), 64'd0);
        rst = 1'b0;
        tick();
        chk("restart_waddr", 64'(rf_waddr), 64'd1);
        repeat (30) tick();
        chk("restart_not_done", 64'(init_done), 64'd0);
        tick();
        chk("restart_done", 64'(init_done), 64'd1);

        // Random traffic honouring the hold-until-ready contract
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 9) < 6) begin
                    pend[i] = 1;
                    drive(i, 1'b1, int'($urandom_range(0, 7)), $urandom);
                end else if (!pend[i]) begin
                    req_valid[i] = 1'b0;
                end
            end
            tick();
            for (int i = 0; i < N; i++) if (last_ready[i]) pend[i] = 0;
        end
        req_valid = '0;
        tick();
        for (int r = 0; r < RN; r++) chk($sformatf("final_x%0d", r), 64'(d_rf[r]), 64'(m_rf[r]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
